// File: rtl/mdu.sv
// Multiply/divide unit: multi-cycle mult/multu/div/divu with architectural HI/LO
// and single-cycle mthi/mtlo. Results land in HI/LO when the busy countdown ends.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W          = 32;
  localparam int unsigned W2         = 64;
  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  pend_hi_q, pend_hi_d;
  logic [W-1:0]  pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic signed [W2-1:0] a_sx, b_sx, prod_s;
  logic [W2-1:0]        a_zx, b_zx, prod_u;
  logic                 a_neg, b_neg, b_zero;
  logic [W-1:0]         a_mag, b_mag, den_s, den_u;
  logic [W-1:0]         q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Full 64-bit products; operands are sampled only at acceptance.
  always_comb begin
    a_sx   = W2'($signed(A));
    b_sx   = W2'($signed(B));
    prod_s = a_sx * b_sx;
    a_zx   = {{(W2-W){1'b0}}, A};
    b_zx   = {{(W2-W){1'b0}}, B};
    prod_u = a_zx * b_zx;
  end

  // Signed division via magnitudes; a zero divisor is replaced by 1 so the
  // divider never sees it (that result is never written back).
  always_comb begin
    a_neg  = A[W-1];
    b_neg  = B[W-1];
    b_zero = (B == '0);
    a_mag  = a_neg ? (-A) : A;
    b_mag  = b_neg ? (-B) : B;
    den_s  = b_zero ? W'(1) : b_mag;
    den_u  = b_zero ? W'(1) : B;
    q_mag  = a_mag / den_s;
    r_mag  = a_mag % den_s;
    q_s    = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
    r_s    = a_neg ? (-r_mag) : r_mag;
    q_u    = A / den_u;
    r_u    = A % den_u;
  end

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (busy_q) begin
      if (cnt_q == CW'(1)) begin
        if (pend_wr_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        cnt_d     = '0;
        busy_d    = 1'b0;
        pend_wr_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          pend_hi_d = prod_s[W2-1:W];
          pend_lo_d = prod_s[W-1:0];
          pend_wr_d = 1'b1;
          cnt_d     = CW'(MULT_CYCLES);
          busy_d    = 1'b1;
        end
        OP_MULTU: begin
          pend_hi_d = prod_u[W2-1:W];
          pend_lo_d = prod_u[W-1:0];
          pend_wr_d = 1'b1;
          cnt_d     = CW'(MULT_CYCLES);
          busy_d    = 1'b1;
        end
        OP_DIV: begin
          pend_hi_d = r_s;
          pend_lo_d = q_s;
          pend_wr_d = !b_zero;
          cnt_d     = CW'(DIV_CYCLES);
          busy_d    = 1'b1;
        end
        OP_DIVU: begin
          pend_hi_d = r_u;
          pend_lo_d = q_u;
          pend_wr_d = !b_zero;
          cnt_d     = CW'(DIV_CYCLES);
          busy_d    = 1'b1;
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  // Synchronous active-low reset also discards any in-flight result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: cycle-accurate reference of HI/LO/busy built from plain
// arithmetic, compared every cycle, plus directed literal checks.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted multi-cycle op finishes busy_end edges later.
  int          edge_k = 0;
  int          busy_end = 0;
  bit          m_inflight = 1'b0;
  bit          m_ok = 1'b0;
  bit          p_wr = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  task automatic compute(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output bit wr);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    wr = 1'b1;
    rh = '0;
    rl = '0;
    case (o)
      3'd1: begin v = 64'(sa * sb); rh = v[63:32]; rl = v[31:0]; end
      3'd2: begin v = ua * ub;      rh = v[63:32]; rl = v[31:0]; end
      3'd3: begin
        if (b == 0) wr = 1'b0;
        else begin
          sq = sa / sb; sr = sa % sb;
          v = 64'(sq); rl = v[31:0];
          v = 64'(sr); rh = v[31:0];
        end
      end
      3'd4: begin
        if (b == 0) wr = 1'b0;
        else begin
          v = ua / ub; rl = v[31:0];
          v = ua % ub; rh = v[31:0];
        end
      end
      default: wr = 1'b0;
    endcase
  endtask

  always @(posedge clk) begin
    edge_k++;
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_inflight = 1'b0; p_wr = 1'b0; m_ok = 1'b1;
    end else if (m_inflight) begin
      if (edge_k == busy_end) begin
        if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        m_inflight = 1'b0;
      end
    end else if (start) begin
      if (op == 3'd5) m_hi = A;
      else if (op == 3'd6) m_lo = A;
      else if (op >= 3'd1 && op <= 3'd4) begin
        compute(op, A, B, p_hi, p_lo, p_wr);
        m_inflight = 1'b1;
        busy_end = edge_k + ((op <= 3'd2) ? MC : DC);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model busy", {31'h0, busy}, {31'h0, m_inflight});
      check("model hi", hi, m_hi);
      check("model lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    reset = 1'b1;

    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult busy cycles", n, MC);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu busy cycles", n, MC);
    check("multu hi", hi, 32'h0000_0001);
    check("multu lo", lo, 32'hFFFF_FFFE);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div busy cycles", n, DC);
    check("div lo", lo, 32'hFFFF_FFFD);
    check("div hi", hi, 32'hFFFF_FFFF);

    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    check("divu0 busy cycles", n, DC);
    check("divu0 lo kept", lo, 32'hFFFF_FFFD);
    check("divu0 hi kept", hi, 32'hFFFF_FFFF);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div ovf lo", lo, 32'h8000_0000);
    check("div ovf hi", hi, 32'h0);

    @(negedge clk);
    start = 1'b1; op = 3'd5; A = 32'h1234_5678;
    @(negedge clk);
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi lo kept", lo, 32'h8000_0000);
    check("mthi busy", {31'h0, busy}, 32'h0);
    op = 3'd6; A = 32'h9ABC_DEF0;
    @(negedge clk);
    check("mtlo lo", lo, 32'h9ABC_DEF0);
    check("mtlo hi kept", hi, 32'h1234_5678);
    check("mtlo busy", {31'h0, busy}, 32'h0);
    op = 3'd0;
    @(negedge clk);
    op = 3'd7; A = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    check("op0/7 hi kept", hi, 32'h1234_5678);
    check("op0/7 lo kept", lo, 32'h9ABC_DEF0);

    // Start held high through the busy window: only the first and the
    // post-busy start take effect.
    issue(3'd1, 32'd7, 32'd6);
    start = 1'b1; op = 3'd1; A = 32'd100; B = 32'd100;
    wait_idle(n);
    check("first mult busy cycles", n, MC);
    check("first mult lo", lo, 32'd42);
    check("first mult hi", hi, 32'd0);
    @(negedge clk);
    start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
    check("b2b accepted", {31'h0, busy}, 32'h1);
    wait_idle(n);
    check("b2b busy cycles", n, MC);
    check("b2b lo", lo, 32'd10000);

    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("abort no late hi", hi, 32'h0);
    check("abort no late lo", lo, 32'h0);

    @(negedge clk);
    reset = 1'b0; start = 1'b1; op = 3'd6; A = 32'h0000_0055;
    @(negedge clk);
    check("start in reset ignored", lo, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first start after reset", lo, 32'h0000_0055);

    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    wait_idle(n);
    check("mult minmin hi", hi, 32'h4000_0000);
    check("mult minmin lo", lo, 32'h0);
    issue(3'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    check("div 7/-2 lo", lo, 32'hFFFF_FFFD);
    check("div 7/-2 hi", hi, 32'd1);

    for (int i = 0; i < 6; i++) begin
      issue(3'($urandom_range(1, 4)), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom);
      wait_idle(n);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
